// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the 4x4 multiplier datapath: the product and
// nibble widths, the narrower's state encoding, and the upper-nibble
// overflow test used when a product is squeezed down to one nibble.
// No ports (package).
// ---------------------------------------------------------------------------
package mult_pkg;

    localparam int PROD_W = 8;
    localparam int NIB_W  = 4;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_e;

    // True when any bit above the low nibble of a product is set, i.e. the
    // product does not fit in a single nibble.
    function automatic logic ovf_of(input logic [PROD_W-1:0] word);
        return |word[PROD_W-1:NIB_W];
    endfunction

endpackage

// File: rtl/product_chunk_narrower.sv
// ---------------------------------------------------------------------------
// product_chunk_narrower
// Takes one IN_W-bit product word and streams it out as OUT_W-bit chunks,
// least-significant chunk first, over valid/ready handshakes. In truncate
// mode only the low chunk is emitted and out_ovf flags any lost upper bits.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    input word offered
//   in_ready    word accepted this cycle (combinational from out_ready)
//   in_data     product word (IN_W bits)
//   in_trunc    truncate mode, sampled with in_data on accept
//   out_valid   chunk presented
//   out_ready   downstream takes the chunk
//   out_data    current chunk (OUT_W bits)
//   out_idx     index of the current chunk, 0 = least significant
//   out_last    current chunk is the final one of the word
//   out_ovf     truncate-mode loss flag, only with out_last
//   ovf_sticky  set by any emitted word with out_ovf, cleared by clr_sticky
//   clr_sticky  synchronous clear of ovf_sticky, wins over a same-cycle set
// ---------------------------------------------------------------------------
module product_chunk_narrower #(
    parameter int OUT_W      = 4,
    parameter int NUM_CHUNKS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [OUT_W*NUM_CHUNKS-1:0]   in_data,
    input  logic                          in_trunc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_W-1:0]              out_data,
    output logic [$clog2(NUM_CHUNKS)-1:0] out_idx,
    output logic                          out_last,
    output logic                          out_ovf,
    output logic                          ovf_sticky,
    input  logic                          clr_sticky
);

    import mult_pkg::*;

    localparam int IN_W  = OUT_W * NUM_CHUNKS;
    localparam int IDX_W = $clog2(NUM_CHUNKS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_e            state_q, state_d;
    logic [IN_W-1:0]   word_q, word_d;
    logic              trunc_q, trunc_d;
    logic              ovf_q, ovf_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              sticky_q, sticky_d;

    logic              inOvf;
    logic              sending;
    logic              lastChunk;
    logic              xfer;
    logic              accept;

    // The multiplier's native geometry uses the shared helper; other
    // parameterisations fall back to the equivalent generic reduction.
    generate
        if (IN_W == PROD_W && OUT_W == NIB_W) begin : g_native_ovf
            assign inOvf = ovf_of(in_data);
        end else begin : g_generic_ovf
            assign inOvf = |in_data[IN_W-1:OUT_W];
        end
    endgenerate

    // Outputs are gated by the SEND state so that IDLE (and reset) present
    // all-zero chunk fields regardless of what is left in the word register.
    // in_ready looks through to out_ready so a new word can be taken on the
    // same edge the final chunk leaves, giving bubble-free streaming.
    always_comb begin
        sending    = (state_q == ST_SEND);
        lastChunk  = trunc_q | (idx_q == LAST_IDX);
        out_valid  = sending;
        out_data   = sending ? word_q[int'(idx_q)*OUT_W +: OUT_W] : '0;
        out_idx    = sending ? idx_q : '0;
        out_last   = sending & lastChunk;
        out_ovf    = sending & trunc_q & ovf_q & lastChunk;
        ovf_sticky = sticky_q;
        xfer       = sending & out_ready;
        in_ready   = (state_q == ST_IDLE) | (xfer & lastChunk);
        accept     = in_valid & in_ready;
    end

    // Next-state logic: load a word on accept (from IDLE or directly after
    // the last chunk), step the chunk index on non-final transfers, and fall
    // back to IDLE when the last chunk leaves with nothing waiting.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        trunc_d  = trunc_q;
        ovf_d    = ovf_q;
        idx_d    = idx_q;
        sticky_d = sticky_q;

        if (accept) begin
            state_d = ST_SEND;
            word_d  = in_data;
            trunc_d = in_trunc;
            ovf_d   = inOvf;
            idx_d   = '0;
        end else if (xfer) begin
            if (lastChunk) begin
                state_d = ST_IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (clr_sticky) begin
            sticky_d = 1'b0;
        end else if (xfer && out_ovf) begin
            sticky_d = 1'b1;
        end
    end

    // State and datapath registers; reset drops any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            word_q   <= '0;
            trunc_q  <= 1'b0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            trunc_q  <= trunc_d;
            ovf_q    <= ovf_d;
            idx_q    <= idx_d;
            sticky_q <= sticky_d;
        end
    end

endmodule

// File: tb/tb_product_chunk_narrower.sv
// ---------------------------------------------------------------------------
// tb_product_chunk_narrower
// Directed scenarios plus a randomized run against a transaction-level model
// that keeps the expected output chunks of every accepted word in a queue.
// ---------------------------------------------------------------------------
module tb_product_chunk_narrower;

    localparam int OUT_W      = 4;
    localparam int NUM_CHUNKS = 2;
    localparam int IN_W       = OUT_W * NUM_CHUNKS;
    localparam int IDX_W      = $clog2(NUM_CHUNKS);

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [IDX_W-1:0] idx;
        logic             last;
        logic             ovf;
    } chunk_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_data;
    logic              in_trunc;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    logic              out_ovf;
    logic              ovf_sticky;
    logic              clr_sticky;

    int compared = 0;
    int failed   = 0;

    chunk_t chunkQ[$];
    logic   stickyM;

    product_chunk_narrower #(
        .OUT_W      (OUT_W),
        .NUM_CHUNKS (NUM_CHUNKS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_trunc   (in_trunc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .clr_sticky (clr_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expand an accepted word into the chunks the downstream should see.
    task automatic push_word(input logic [IN_W-1:0] w, input logic t);
        chunk_t c;
        if (t) begin
            c.data = w[OUT_W-1:0];
            c.idx  = '0;
            c.last = 1'b1;
            c.ovf  = ((w >> OUT_W) != 0);
            chunkQ.push_back(c);
        end else begin
            for (int i = 0; i < NUM_CHUNKS; i++) begin
                c.data = OUT_W'((w >> (i * OUT_W)) & ((1 << OUT_W) - 1));
                c.idx  = IDX_W'(i);
                c.last = (i == NUM_CHUNKS - 1);
                c.ovf  = 1'b0;
                chunkQ.push_back(c);
            end
        end
    endtask

    // Expected in_ready: nothing pending, or the final pending chunk leaves now.
    function automatic logic model_ready();
        if (chunkQ.size() == 0) return 1'b1;
        return chunkQ[0].last && out_ready;
    endfunction

    // Apply the current inputs to the model, then let the clock edge happen.
    task automatic advance();
        logic   rdy;
        logic   s;
        chunk_t c;
        rdy = model_ready();
        s   = stickyM;
        if (rst_n) begin
            if (chunkQ.size() > 0 && out_ready) begin
                c = chunkQ.pop_front();
                if (c.ovf) s = 1'b1;
            end
            if (clr_sticky) s = 1'b0;
            if (in_valid && rdy) push_word(in_data, in_trunc);
        end
        stickyM = s;
        @(posedge clk);
    endtask

    // Drive a new set of inputs between edges and let outputs settle.
    task automatic drive(input logic v, input logic [IN_W-1:0] d, input logic t,
                         input logic r, input logic c);
        @(negedge clk);
        in_valid   = v;
        in_data    = d;
        in_trunc   = t;
        out_ready  = r;
        clr_sticky = c;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_data = '0; in_trunc = 0; out_ready = 0; clr_sticky = 0;
        chunkQ.delete();
        stickyM = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compared++; if (out_valid !== 1'b0) begin failed++; $display("[TB] FAIL reset_valid: got %b want 0", out_valid); end
        compared++; if (out_data !== 4'h0) begin failed++; $display("[TB] FAIL reset_data: got %h want 0", out_data); end
        compared++; if (ovf_sticky !== 1'b0) begin failed++; $display("[TB] FAIL reset_sticky: got %b want 0", ovf_sticky); end
        rst_n = 1'b1;

        // Load 8'hA5 and reset while chunk 0 is held.
        drive(1, 8'hA5, 0, 0, 0);
        advance();
        drive(0, 8'h00, 0, 0, 0);
        compared++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin failed++; $display("[TB] FAIL midword_loaded: got v=%b d=%h want v=1 d=5", out_valid, out_data); end
        rst_n = 1'b0;
        chunkQ.delete();
        stickyM = 1'b0;
        #1;
        compared++; if (out_valid !== 1'b0) begin failed++; $display("[TB] FAIL midword_reset_valid: got %b want 0", out_valid); end
        compared++; if (out_data !== 4'h0 || out_idx !== '0 || out_last !== 1'b0 || out_ovf !== 1'b0)
            begin failed++; $display("[TB] FAIL midword_reset_fields: got d=%h i=%0d l=%b o=%b want all 0", out_data, out_idx, out_last, out_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(0, 8'hFF, 0, 1, 0);
            compared++; if (out_valid !== 1'b0) begin failed++; $display("[TB] FAIL post_reset_idle%0d: got %b want 0", k, out_valid); end
            advance();
        end
    endtask

    task automatic test_full_mode();
        drive(1, 8'h3C, 0, 1, 0);
        advance();
        drive(0, 8'h00, 0, 1, 0);
        compared++; if (out_data !== 4'hC || out_idx !== 1'd0 || out_last !== 1'b0)
            begin failed++; $display("[TB] FAIL full_chunk0: got d=%h i=%0d l=%b want d=c i=0 l=0", out_data, out_idx, out_last); end
        compared++; if (in_ready !== 1'b0) begin failed++; $display("[TB] FAIL full_ready0: got %b want 0", in_ready); end
        advance();
        drive(0, 8'h00, 0, 1, 0);
        compared++; if (out_data !== 4'h3 || out_idx !== 1'd1 || out_last !== 1'b1 || out_ovf !== 1'b0)
            begin failed++; $display("[TB] FAIL full_chunk1: got d=%h i=%0d l=%b o=%b want d=3 i=1 l=1 o=0", out_data, out_idx, out_last, out_ovf); end
        advance();
        drive(0, 8'h00, 0, 1, 0);
        compared++; if (out_valid !== 1'b0 || ovf_sticky !== 1'b0)
            begin failed++; $display("[TB] FAIL full_done: got v=%b s=%b want v=0 s=0", out_valid, ovf_sticky); end
    endtask

    task automatic test_trunc_back_to_back();
        drive(1, 8'h0F, 1, 1, 0);
        advance();
        drive(1, 8'h1F, 1, 1, 0);
        compared++; if (out_data !== 4'hF || out_last !== 1'b1 || out_ovf !== 1'b0)
            begin failed++; $display("[TB] FAIL trunc_w0: got d=%h l=%b o=%b want d=f l=1 o=0", out_data, out_last, out_ovf); end
        compared++; if (in_ready !== 1'b1) begin failed++; $display("[TB] FAIL trunc_ready: got %b want 1", in_ready); end
        advance();
        drive(0, 8'h00, 0, 1, 0);
        compared++; if (out_valid !== 1'b1 || out_data !== 4'hF || out_ovf !== 1'b1)
            begin failed++; $display("[TB] FAIL trunc_w1: got v=%b d=%h o=%b want v=1 d=f o=1", out_valid, out_data, out_ovf); end
        advance();
        drive(0, 8'h00, 0, 1, 1);
        compared++; if (ovf_sticky !== 1'b1 || out_valid !== 1'b0)
            begin failed++; $display("[TB] FAIL trunc_sticky_set: got s=%b v=%b want s=1 v=0", ovf_sticky, out_valid); end
        advance();
        drive(0, 8'h00, 0, 1, 0);
        compared++; if (ovf_sticky !== 1'b0) begin failed++; $display("[TB] FAIL trunc_sticky_clr: got %b want 0", ovf_sticky); end
    endtask

    task automatic test_backpressure();
        drive(1, 8'hE1, 0, 1, 0);
        advance();
        for (int k = 0; k < 3; k++) begin
            drive(1, 8'h77, 0, 0, 0);
            compared++; if (out_valid !== 1'b1 || out_data !== 4'h1 || out_idx !== 1'd0 || in_ready !== 1'b0)
                begin failed++; $display("[TB] FAIL bp_hold%0d: got v=%b d=%h i=%0d r=%b want v=1 d=1 i=0 r=0", k, out_valid, out_data, out_idx, in_ready); end
            advance();
        end
        drive(0, 8'h00, 0, 1, 0);
        compared++; if (out_data !== 4'h1) begin failed++; $display("[TB] FAIL bp_release0: got %h want 1", out_data); end
        advance();
        drive(0, 8'h00, 0, 1, 0);
        compared++; if (out_data !== 4'hE || out_last !== 1'b1) begin failed++; $display("[TB] FAIL bp_release1: got d=%h l=%b want d=e l=1", out_data, out_last); end
        advance();
    endtask

    task automatic test_back_to_back();
        logic [IN_W-1:0] words [3];
        logic [OUT_W-1:0] expd [6];
        int k;
        words = '{8'h12, 8'h34, 8'h56};
        expd  = '{4'h2, 4'h1, 4'h4, 4'h3, 4'h6, 4'h5};
        k = 0;
        for (int c = 0; c <= 7; c++) begin
            drive(k < 3, (k < 3) ? words[k] : 8'h00, 0, 1, 0);
            if (c >= 1 && c <= 6) begin
                compared++; if (out_valid !== 1'b1 || out_data !== expd[c-1])
                    begin failed++; $display("[TB] FAIL stream_c%0d: got v=%b d=%h want v=1 d=%h", c, out_valid, out_data, expd[c-1]); end
            end
            if (c <= 6) begin
                compared++; if (in_ready !== (c % 2 == 0))
                    begin failed++; $display("[TB] FAIL stream_ready_c%0d: got %b want %b", c, in_ready, (c % 2 == 0)); end
            end else begin
                compared++; if (out_valid !== 1'b0) begin failed++; $display("[TB] FAIL stream_end: got %b want 0", out_valid); end
            end
            if (k < 3 && c % 2 == 0) k++;
            advance();
        end
    endtask

    task automatic test_clear_vs_set();
        drive(1, 8'hF0, 1, 1, 0);
        advance();
        drive(0, 8'h00, 0, 1, 1);
        compared++; if (out_ovf !== 1'b1 || out_last !== 1'b1 || out_data !== 4'h0)
            begin failed++; $display("[TB] FAIL clrset_chunk: got o=%b l=%b d=%h want o=1 l=1 d=0", out_ovf, out_last, out_data); end
        advance();
        drive(0, 8'h00, 0, 1, 0);
        compared++; if (ovf_sticky !== 1'b0) begin failed++; $display("[TB] FAIL clrset_sticky: got %b want 0", ovf_sticky); end
        advance();
    endtask

    task automatic test_random();
        chunk_t exp;
        logic   expValid;
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 1) == 1, IN_W'($urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
            expValid = (chunkQ.size() > 0);
            if (expValid) exp = chunkQ[0];
            else begin exp.data = '0; exp.idx = '0; exp.last = 1'b0; exp.ovf = 1'b0; end
            compared++; if (out_valid !== expValid) begin failed++; $display("[TB] FAIL rnd%0d_valid: got %b want %b", n, out_valid, expValid); end
            compared++; if (in_ready !== model_ready()) begin failed++; $display("[TB] FAIL rnd%0d_ready: got %b want %b", n, in_ready, model_ready()); end
            compared++; if (out_data !== exp.data || out_idx !== exp.idx)
                begin failed++; $display("[TB] FAIL rnd%0d_chunk: got d=%h i=%0d want d=%h i=%0d", n, out_data, out_idx, exp.data, exp.idx); end
            compared++; if (out_last !== exp.last || out_ovf !== exp.ovf)
                begin failed++; $display("[TB] FAIL rnd%0d_flags: got l=%b o=%b want l=%b o=%b", n, out_last, out_ovf, exp.last, exp.ovf); end
            compared++; if (ovf_sticky !== stickyM) begin failed++; $display("[TB] FAIL rnd%0d_sticky: got %b want %b", n, ovf_sticky, stickyM); end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_full_mode();
        test_trunc_back_to_back();
        test_backpressure();
        test_back_to_back();
        test_clear_vs_set();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
